// File: rtl/alu_seq_if.sv
// Request/response handshake and alu_total port bundle for alu_seq.
// The master side is the decoder plus the alu_total instance; the slave side is the sequencer.
interface alu_seq_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [1:0]  i_op;
  logic [1:0]  i_fmt;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [4:0]  i_amt;
  logic        o_done;
  logic [31:0] o_result;
  logic [31:0] o_alu_reg0;
  logic [31:0] o_alu_reg1;
  logic [3:0]  o_alu_action;
  logic [1:0]  o_alu_fmt;
  logic [31:0] i_alu_out;

  modport master (
    output i_req_valid, i_op, i_fmt, i_a, i_b, i_amt, i_alu_out,
    input  o_req_ready, o_done, o_result, o_alu_reg0, o_alu_reg1, o_alu_action, o_alu_fmt
  );

  modport slave (
    input  i_req_valid, i_op, i_fmt, i_a, i_b, i_amt, i_alu_out,
    output o_req_ready, o_done, o_result, o_alu_reg0, o_alu_reg1, o_alu_action, o_alu_fmt
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle shift/multiply sequencer: steps the shared alu_total datapath one operation per
// cycle, feeding each ALU result back into its own registers.
module alu_seq (
  input logic      i_clk,
  input logic      i_rst,
  alu_seq_if.slave bus
);

  localparam logic [1:0] FMT_1B  = 2'd0;
  localparam logic [1:0] FMT_2B  = 2'd1;
  localparam logic [3:0] ALU_MOV = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_LSL = 4'd2;
  localparam logic [3:0] ALU_LSR = 4'd3;
  localparam logic [1:0] OpShl   = 2'd0;
  localparam logic [1:0] OpShr   = 2'd1;
  localparam logic [1:0] OpMul   = 2'd2;

  typedef enum logic [2:0] {StIdle, StShift, StMadd, StMshift, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  fmt_q, fmt_d;
  logic [4:0]  amt_q, amt_d;
  logic [4:0]  k_q, k_d;
  logic [31:0] b_q, b_d;
  logic [31:0] work_q, work_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  logic        req_ready;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_reg0;
  logic [31:0] alu_reg1;
  logic [3:0]  alu_action;

  function automatic logic [31:0] low_mask(input logic [1:0] fmt);
    case (fmt)
      FMT_1B:  return 32'h0000_00ff;
      FMT_2B:  return 32'h0000_ffff;
      default: return 32'hffff_ffff;
    endcase
  endfunction

  function automatic logic [4:0] top_bit(input logic [1:0] fmt);
    case (fmt)
      FMT_1B:  return 5'd7;
      FMT_2B:  return 5'd15;
      default: return 5'd31;
    endcase
  endfunction

  assign req_ready = (state_q == StIdle) && !i_rst;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    fmt_d      = fmt_q;
    amt_d      = amt_q;
    k_d        = k_q;
    b_d        = b_q;
    work_d     = work_q;
    acc_d      = acc_q;
    result_d   = result_q;
    done       = 1'b0;
    result     = result_q;
    alu_reg0   = 32'd0;
    alu_reg1   = 32'd0;
    alu_action = ALU_MOV;

    unique case (state_q)
      StIdle: begin
        if (bus.i_req_valid && req_ready) begin
          op_d   = bus.i_op;
          fmt_d  = bus.i_fmt;
          amt_d  = bus.i_amt;
          b_d    = bus.i_b;
          k_d    = 5'd0;
          work_d = bus.i_a;
          // Upper bits ride along untouched; only the low W bits accumulate the product.
          acc_d  = bus.i_a & ~low_mask(bus.i_fmt);
          unique case (bus.i_op)
            OpShl, OpShr: state_d = (bus.i_amt == 5'd0) ? StDone : StShift;
            OpMul:        state_d = bus.i_b[0] ? StMadd : StMshift;
            default:      state_d = StDone;
          endcase
        end
      end
      StShift: begin
        alu_reg0   = work_q;
        // alu_total names its shift actions opposite to their direction.
        alu_action = (op_q == OpShl) ? ALU_LSR : ALU_LSL;
        work_d     = bus.i_alu_out;
        amt_d      = amt_q - 5'd1;
        if (amt_q == 5'd1) state_d = StDone;
      end
      StMadd: begin
        alu_reg0   = acc_q;
        alu_reg1   = work_q;
        alu_action = ALU_ADD;
        acc_d      = bus.i_alu_out;
        state_d    = StMshift;
      end
      StMshift: begin
        alu_reg0   = work_q;
        alu_action = ALU_LSR;
        work_d     = bus.i_alu_out;
        k_d        = k_q + 5'd1;
        if (k_q == top_bit(fmt_q)) begin
          state_d = StDone;
        end else begin
          state_d = b_q[k_q + 5'd1] ? StMadd : StMshift;
        end
      end
      StDone: begin
        done     = 1'b1;
        result   = (op_q == OpMul) ? acc_q : work_q;
        result_d = result;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      op_q     <= 2'd0;
      fmt_q    <= 2'd0;
      amt_q    <= 5'd0;
      k_q      <= 5'd0;
      b_q      <= 32'd0;
      work_q   <= 32'd0;
      acc_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      fmt_q    <= fmt_d;
      amt_q    <= amt_d;
      k_q      <= k_d;
      b_q      <= b_d;
      work_q   <= work_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_done       = done;
  assign bus.o_result     = result;
  assign bus.o_alu_reg0   = alu_reg0;
  assign bus.o_alu_reg1   = alu_reg1;
  assign bus.o_alu_action = alu_action;
  assign bus.o_alu_fmt    = fmt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a behavioural alu_total, a per-cycle reference checker and directed vectors.
module tb_alu_seq;

  localparam logic [1:0] FMT_1B  = 2'd0;
  localparam logic [1:0] FMT_2B  = 2'd1;
  localparam logic [1:0] FMT_4B  = 2'd2;
  localparam logic [3:0] ALU_MOV = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_LSL = 4'd2;
  localparam logic [3:0] ALU_LSR = 4'd3;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  alu_seq_if bus ();

  alu_seq u_dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mask_of(input logic [1:0] fmt);
    if (fmt == FMT_1B) return 32'h0000_00ff;
    if (fmt == FMT_2B) return 32'h0000_ffff;
    return 32'hffff_ffff;
  endfunction

  // alu_total: operates on the low W bits, upper bits of reg0 pass through.
  function automatic logic [31:0] alu_fn(input logic [31:0] r0, input logic [31:0] r1,
                                         input logic [3:0] act, input logic [1:0] fmt);
    logic [31:0] m;
    m = mask_of(fmt);
    case (act)
      ALU_ADD: return (r0 & ~m) | ((r0 + r1) & m);
      ALU_LSR: return (r0 & ~m) | ((r0 << 1) & m);
      ALU_LSL: return (r0 & ~m) | ((r0 & m) >> 1);
      default: return r0;
    endcase
  endfunction

  assign bus.i_alu_out = alu_fn(bus.o_alu_reg0, bus.o_alu_reg1, bus.o_alu_action, bus.o_alu_fmt);

  function automatic logic [31:0] exp_result(input logic [1:0] op, input logic [1:0] fmt,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] amt);
    logic [31:0] m;
    logic [63:0] p;
    m = mask_of(fmt);
    case (op)
      2'd0: return (a & ~m) | ((a << amt) & m);
      2'd1: return (a & ~m) | ((a & m) >> amt);
      2'd2: begin
        p = {32'd0, a & m} * {32'd0, b & m};
        return (a & ~m) | (p[31:0] & m);
      end
      default: return a;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [1:0] fmt,
                                     input logic [31:0] b, input logic [4:0] amt);
    int w;
    w = (fmt == FMT_1B) ? 8 : (fmt == FMT_2B) ? 16 : 32;
    case (op)
      2'd0, 2'd1: return (amt == 5'd0) ? 1 : int'(amt) + 1;
      2'd2:       return w + $countones(b & mask_of(fmt)) + 1;
      default:    return 1;
    endcase
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference checker: tracks one outstanding request and compares every cycle.
  bit          m_busy = 1'b0;
  int          m_cyc = 0;
  int          m_lat = 0;
  logic [31:0] m_exp = 32'd0;
  logic [31:0] m_held = 32'd0;

  always @(negedge i_clk) begin
    if (chk_en) begin
      if (m_busy) begin
        m_cyc++;
        if (m_cyc == m_lat) begin
          check_eq("done_pulse", 32'(bus.o_done), 32'd1);
          check_eq("done_result", bus.o_result, m_exp);
          check_eq("done_alu_mov", 32'(bus.o_alu_action), 32'(ALU_MOV));
          m_held = m_exp;
          m_busy = 1'b0;
        end else begin
          check_eq("busy_no_done", 32'(bus.o_done), 32'd0);
        end
        check_eq("busy_not_ready", 32'(bus.o_req_ready), 32'd0);
      end else begin
        check_eq("idle_no_done", 32'(bus.o_done), 32'd0);
        check_eq("idle_ready", 32'(bus.o_req_ready), 32'(!i_rst));
        check_eq("idle_result_held", bus.o_result, m_held);
        check_eq("idle_alu_mov", 32'(bus.o_alu_action), 32'(ALU_MOV));
        check_eq("idle_alu_reg0", bus.o_alu_reg0, 32'd0);
      end
      if (i_rst) begin
        m_busy = 1'b0;
        m_held = 32'd0;
      end else if (!m_busy && bus.i_req_valid && bus.o_req_ready) begin
        m_busy = 1'b1;
        m_cyc  = 0;
        m_exp  = exp_result(bus.i_op, bus.i_fmt, bus.i_a, bus.i_b, bus.i_amt);
        m_lat  = exp_latency(bus.i_op, bus.i_fmt, bus.i_b, bus.i_amt);
      end
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  fmt;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  amt;
    logic [31:0] res;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic set_req(input vec_t v);
    bus.i_op  = v.op;
    bus.i_fmt = v.fmt;
    bus.i_a   = v.a;
    bus.i_b   = v.b;
    bus.i_amt = v.amt;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input vec_t v, input bit hold);
    int n;
    set_req(v);
    bus.i_req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!bus.o_req_ready && n < 20);
    if (!bus.o_req_ready) check_eq("accept_timeout", 32'(bus.o_req_ready), 32'd1);
    @(posedge i_clk);
    #1;
    if (!hold) bus.i_req_valid = 1'b0;
  endtask

  task automatic await_done(output int c, output bit got);
    c = 0;
    got = 1'b0;
    while (c < 200 && !got) begin
      @(negedge i_clk);
      c++;
      got = bus.o_done;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int c;
    bit got;
    issue(v, 1'b0);
    await_done(c, got);
    check_eq({name, "_cycle"}, 32'(c), 32'(v.cyc));
    check_eq({name, "_result"}, bus.o_result, v.res);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int  c;
    bit  got;
    int  seen;
    vec_t v2;
    vecs[0] = '{2'd0, FMT_4B, 32'h0000_0001, 32'd0, 5'd4,  32'h0000_0010, 5};
    vecs[1] = '{2'd1, FMT_1B, 32'hAABB_CC80, 32'd0, 5'd3,  32'hAABB_CC10, 4};
    vecs[2] = '{2'd1, FMT_1B, 32'hAABB_CC80, 32'd0, 5'd9,  32'hAABB_CC00, 10};
    vecs[3] = '{2'd2, FMT_4B, 32'd7,         32'd6, 5'd0,  32'd42,        35};
    vecs[4] = '{2'd2, FMT_1B, 32'hFFFF_FF0F, 32'd3, 5'd0,  32'hFFFF_FF2D, 11};
    vecs[5] = '{2'd0, FMT_4B, 32'h1234_5678, 32'd0, 5'd0,  32'h1234_5678, 1};
    vecs[6] = '{2'd3, FMT_4B, 32'h1234_5678, 32'd5, 5'd7,  32'h1234_5678, 1};
    vecs[7] = '{2'd2, FMT_2B, 32'h1234_0100, 32'hFFFF_0300, 5'd0, 32'h1234_0000, 19};
    vecs[8] = '{2'd0, FMT_2B, 32'hABCD_8001, 32'd0, 5'd15, 32'hABCD_8000, 16};
    vecs[9] = '{2'd1, FMT_4B, 32'h8000_0000, 32'd0, 5'd31, 32'h0000_0001, 32};

    bus.i_req_valid = 1'b0;
    set_req(vecs[0]);
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("reset_done", 32'(bus.o_done), 32'd0);
    check_eq("reset_result", bus.o_result, 32'd0);
    check_eq("reset_ready_low", 32'(bus.o_req_ready), 32'd0);
    check_eq("reset_alu_fmt", 32'(bus.o_alu_fmt), 32'd0);
    i_rst  = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with valid held high.
    v2 = '{2'd1, FMT_2B, 32'h0000_F000, 32'd0, 5'd4, 32'h0000_0F00, 5};
    issue(vecs[0], 1'b1);
    set_req(v2);
    await_done(c, got);
    check_eq("b2b_first_cycle", 32'(c), 32'd5);
    check_eq("b2b_first_result", bus.o_result, 32'h0000_0010);
    @(negedge i_clk);
    check_eq("b2b_second_accept", 32'(bus.o_req_ready), 32'd1);
    @(posedge i_clk);
    #1;
    bus.i_req_valid = 1'b0;
    await_done(c, got);
    check_eq("b2b_second_cycle", 32'(c), 32'd5);
    check_eq("b2b_second_result", bus.o_result, 32'h0000_0F00);
    @(posedge i_clk);
    #1;

    // Reset in cycle 10 of a 32-bit multiply.
    issue(vecs[3], 1'b0);
    repeat (9) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check_eq("abort_ready", 32'(bus.o_req_ready), 32'd1);
    check_eq("abort_result", bus.o_result, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (bus.o_done) seen++;
    end
    check_eq("abort_no_done", 32'(seen), 32'd0);
    @(posedge i_clk);
    #1;
    run_vec(vecs[4], "after_abort");

    repeat (3) @(posedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle operation sequencer for the shared `alu_total` datapath. It accepts one request at a time for variable-distance shifts and integer multiply, then drives `alu_total` for one step per cycle, feeding each registered result back as the next operand. It sits between the execute-stage decoder and the single `alu_total` instance. All arithmetic goes through the ALU port; the block itself holds only registers, counters and the FSM.

## Interface
Parameters: none.

Ports:
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: block can accept; `(state==IDLE) && !i_rst`.
- `i_op` in 2: 0 shift left, 1 logical shift right, 2 multiply, 3 reserved.
- `i_fmt` in 2: `FMT_1B` gives W=8, `FMT_2B` gives W=16, any other value gives W=32.
- `i_a` in 32: shift operand or multiplicand.
- `i_b` in 32: multiplier; only `i_b[W-1:0]` is used.
- `i_amt` in 5: shift distance, 0..31.
- `o_done` out 1: one-cycle pulse; `o_result` is valid.
- `o_result` out 32: result, held until the next accept.
- `o_alu_reg0` out 32: to `alu_total` `i_reg0`.
- `o_alu_reg1` out 32: to `alu_total` `i_reg1`.
- `o_alu_action` out 4: to `alu_total` `i_alu_action`.
- `o_alu_fmt` out 2: to `alu_total` `i_fmt`; equals the latched fmt.
- `i_alu_out` in 32: from `alu_total` `o_alu_out`.

## Operation
- Accept: `i_req_valid && o_req_ready` at a rising edge. On accept, latch op, fmt, amt and `b = i_b`.
  - Set `work = i_a`.
  - Set `acc = {i_a[31:W], W'b0}`.
  - Set `k = 0`.
- States are IDLE, SHIFT, MADD, MSHIFT, DONE.
- Left shift uses the action yielding `reg0<<1` (`ALU_LSR`). Right shift uses `reg0>>1` (`ALU_LSL`).
- From IDLE on accept:
  - op 0 or 1 with amt>0 goes to SHIFT.
  - op 0 or 1 with amt=0 goes to DONE.
  - op 3 goes to DONE with result `i_a`.
  - op 2 goes to MADD if `b[0]`, otherwise to MSHIFT.
- SHIFT:
  - ALU drive: reg0=`work`, action = left or right shift per op.
  - Each cycle: `work <= i_alu_out`, `amt <= amt-1`.
  - At amt==1, go to DONE.
- MADD:
  - ALU drive: reg0=`acc`, reg1=`work`, action `ALU_ADD`.
  - `acc <= i_alu_out`, then go to MSHIFT.
- MSHIFT:
  - ALU drive: reg0=`work`, action left shift.
  - `work <= i_alu_out`, `k <= k+1`.
  - If `k==W-1`, go to DONE.
  - Otherwise go to MADD if `b[k+1]`, else MSHIFT.
- DONE:
  - `o_done=1`.
  - `o_result` = `work` for shifts and op 3, `acc` for multiply.
  - Next state IDLE.
- Width rules: bits `[31:W]` pass through unchanged, because `alu_total` preserves the upper bits of reg0.
  - Shifts by `amt>=W` give zero low W bits.
  - Multiply gives product mod 2^W in the low bits, `i_a[31:W]` above.
- In IDLE and DONE, the ALU is driven with reg0=0, reg1=0, action `ALU_MOV`.

## Timing
- Reset (edge with `i_rst=1`):
  - state goes to IDLE, registers clear.
  - `o_done=0`, `o_result=0`.
  - `o_alu_reg0=0`, `o_alu_reg1=0`, `o_alu_action=ALU_MOV`, `o_alu_fmt=0`.
  - `o_req_ready=0` while `i_rst` is high.
- Reset mid-operation aborts the operation with no `o_done` and the result discarded. IDLE is ready on the first cycle after `i_rst` deasserts.
- Cycle numbering: accept in cycle 0.
  - Shift by n>0: SHIFT in cycles 1..n, `o_done` in cycle n+1.
  - amt=0 or op 3: `o_done` in cycle 1.
  - Multiply: W MSHIFT cycles plus popcount(`b[W-1:0]`) MADD cycles, then `o_done` in cycle W+pop+1. There is no early termination.
- `o_req_ready` is low from cycle 1 through DONE. Earliest next accept is the cycle after DONE, so back-to-back throughput is one idle cycle.
- Inputs other than valid are ignored when not accepting.
- ALU path is combinational from this block's registers through `alu_total` and back into them, one step per cycle.

## Test plan
- op0, FMT_4B, a=0x00000001, amt=4 -> o_done in cycle 5, o_result=0x00000010.
- op1, FMT_1B, a=0xAABBCC80, amt=3 -> o_done in cycle 4, o_result=0xAABBCC10; amt=9 -> 0xAABBCC00 in cycle 10.
- op2, FMT_4B, a=7, b=6 -> o_done in cycle 35, o_result=42. op2, FMT_1B, a=0xFFFFFF0F, b=3 -> o_done in cycle 11, o_result=0xFFFFFF2D.
- op0 with amt=0 and op3, a=0x12345678 -> o_done in cycle 1, o_result=0x12345678; ALU action stays `ALU_MOV`.
- Back-to-back: valid held high across two requests -> second accept exactly one cycle after the first o_done, results correct and independent.
- Reset asserted in cycle 10 of the 32-bit multiply -> no o_done, o_result=0, o_req_ready=1 the cycle after reset deasserts, new request completes correctly.
